// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable N-bit pattern, overlap mode and a saturating match counter.
// Define SEQDET_COUNT_EN to build the match counter; otherwise match_cnt and cnt_sat are tied to 0.
module seq_detect_param #(
   parameter int unsigned N                      = 4,
   parameter logic [N-1:0] RESET_PATTERN         = N'(4'b1101),
   parameter int unsigned CNT_W                  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             seq,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [N-1:0]     pat_in,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int unsigned FILL_W = $clog2(N + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

   logic [N-1:0]      pat;
   logic [N-1:0]      hist;
   logic [FILL_W-1:0] fill;

   logic [N-1:0]      hist_nxt_c;
   logic [FILL_W-1:0] fill_inc_c;
   logic              match_c;

   // Candidate window and fill level if the current bit were accepted
   always_comb begin
      hist_nxt_c = {hist[N-2:0], seq};
      fill_inc_c = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      match_c    = in_valid && !pat_load && (fill_inc_c == FILL_FULL) && (hist_nxt_c == pat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat  <= RESET_PATTERN;
         hist <= '0;
         fill <= '0;
         out  <= 1'b0;
      end else begin
         out <= match_c;
         if (pat_load) begin
            pat  <= pat_in;
            hist <= '0;
            fill <= '0;
         end else if (in_valid) begin
            hist <= hist_nxt_c;
            // Non-overlapping mode restarts the window so no matched bit is reused
            fill <= (match_c && !overlap) ? '0 : fill_inc_c;
         end
      end
   end

`ifdef SEQDET_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (match_c && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + CNT_W'(1);
         cnt_sat   <= ((match_cnt + CNT_W'(1)) == CNT_MAX);
      end
   end
`else
   assign match_cnt = '0;
   assign cnt_sat   = 1'b0;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
- REQ-001 SHALL have parameter N, default 4: pattern length in bits, legal range 2..16.
- REQ-002 SHALL have parameter RESET_PATTERN, default 4'b1101 (N bits): pattern in force after reset.
- REQ-003 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 SHALL have port in_valid, input, 1 bit: seq is sampled only when in_valid=1.
- REQ-007 SHALL have port seq, input, 1 bit: serial input bit.
- REQ-008 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
- REQ-009 SHALL have port pat_load, input, 1 bit: one-cycle strobe that loads pat_in.
- REQ-010 SHALL have port pat_in, input, N bits: new pattern; pat_in[N-1] is the first bit received, pat_in[0] the last.
- REQ-011 SHALL have port out, output, 1 bit: registered Moore match flag.
- REQ-012 SHALL have port match_cnt, output, CNT_W bits: count of matches.
- REQ-013 SHALL have port cnt_sat, output, 1 bit: 1 while match_cnt is at its maximum value.

Function
- REQ-014 SHALL hold internal state: pattern register pat (N bits), history shift register hist (N bits), fill counter fill (0..N, $clog2(N+1) bits).
- REQ-015 On each edge with in_valid=1 and pat_load=0: hist_next = {hist[N-2:0], seq} and fill_next = min(fill+1, N).
- REQ-016 A match SHALL occur on that edge iff fill_next==N and hist_next==pat.
- REQ-017 out SHALL be 1 for exactly the one cycle after the edge that sampled the completing bit, and 0 otherwise; out SHALL NOT depend combinationally on any input.
- REQ-018 On a match with overlap=0, fill SHALL become 0, so no bit of the matched window is reused.
- REQ-019 On a match with overlap=1, fill SHALL stay at N, so a match is possible on every valid bit.
- REQ-020 overlap SHALL be sampled on the edge of the match decision; a mode change takes effect on the next valid bit.
- REQ-021 With in_valid=0, hist, fill and match_cnt SHALL hold, and out SHALL be 0 on the next cycle.
- REQ-022 pat_load=1 SHALL load pat <= pat_in and clear fill and hist to 0; no match occurs on that edge.
- REQ-023 When pat_load=1 and in_valid=1 on the same edge, pat_load SHALL take priority and the seq bit SHALL be discarded.
- REQ-024 match_cnt SHALL increment by 1 on each match and saturate at 2^CNT_W-1, with no wrap-around.
- REQ-025 cnt_sat SHALL be registered and equal (match_cnt == 2^CNT_W-1).

Reset
- REQ-026 With rst=1 at an edge: pat=RESET_PATTERN, hist=0, fill=0, out=0, match_cnt=0, cnt_sat=0.
- REQ-027 rst SHALL override pat_load and in_valid on the same edge.
- REQ-028 A reset asserted mid-pattern SHALL discard partial progress; the first match after release needs N fresh valid bits.

Configuration
- REQ-029 Macro SEQDET_COUNT_EN defined: match_cnt and cnt_sat SHALL behave per REQ-024/025.
- REQ-030 SEQDET_COUNT_EN undefined: counter logic SHALL be omitted and match_cnt and cnt_sat tied to 0; out and detection SHALL be unchanged.

Verification
- REQ-031 Reset pattern 1101, overlap=0, bits 1,1,0,1,1,0,1 with in_valid=1 every cycle -> out pulses once (cycle after bit 4); match_cnt=1.
- REQ-032 Same stream with overlap=1 -> out pulses after bit 4 and after bit 7; match_cnt=2.
- REQ-033 Bits 1,1,0,1 with in_valid=0 for 3 cycles between bits 2 and 3 -> single out pulse after bit 4; out=0 during the gaps.
- REQ-034 After bits 1,1,0, apply pat_load with pat_in=0110 together with in_valid=1 -> that bit is discarded; then 0,1,1,0 -> out pulses after the last 0; then 1 -> no pulse.
- REQ-035 CNT_W=2, overlap=1, bits 1,1,0,1,1,0,1,1,0,1,1,0,1 (4 matches) -> match_cnt 1,2,3,3; cnt_sat=1 after the 3rd match.
- REQ-036 rst=1 for one cycle after bits 1,1,0, then bit 1 -> no pulse; match_cnt=0; a full 1101 is then required for a pulse.
